// File: rtl/scope_dump_ctrl.sv
// Reads one captured channel trace out of the capture RAMs, oldest sample first,
// and hands each byte to the UART with a trmt/tx_done handshake.
module scope_dump_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int NUM_CH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dump,
  input  logic [1:0]            ch_sel,
  input  logic [ADDR_W-1:0]     trace_end,
  input  logic                  abort,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [NUM_CH-1:0]     ram_en,
  input  logic [NUM_CH*8-1:0]   ram_rdata,
  output logic [7:0]            tx_data,
  output logic                  trmt,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  dump_fin
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, WAIT_TX, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [1:0]        ch_q;
  logic [ADDR_W-1:0] count;
  logic [7:0]        rd_byte;
  logic              ch_ok;

  assign ch_ok = int'(ch_sel) < NUM_CH;

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch_q) == i) rd_byte = ram_rdata[8*i +: 8];
    end
  end

  // Strobes are decoded from state so abort can kill them in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_en
      assign ram_en[gi] = (state == READ) && (int'(ch_q) == gi) && !abort;
    end
  endgenerate

  assign trmt = (state == SEND) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch_q     <= '0;
      count    <= '0;
      ram_addr <= '0;
      tx_data  <= '0;
      busy     <= 1'b0;
      dump_fin <= 1'b0;
    end else begin
      dump_fin <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (dump) begin
              busy <= 1'b1;
              if (ch_ok) begin
                ch_q     <= ch_sel;
                ram_addr <= trace_end + 1'b1;
                count    <= '0;
                state    <= READ;
              end else begin
                state <= FIN;
              end
            end
          end
          READ:  state <= LATCH;
          LATCH: begin
            tx_data <= rd_byte;
            state   <= SEND;
          end
          SEND:  state <= WAIT_TX;
          WAIT_TX: begin
            if (tx_done) begin
              count <= count + 1'b1;
              if (count == LAST) begin
                state <= FIN;
              end else begin
                ram_addr <= ram_addr + 1'b1;
                state    <= READ;
              end
            end
          end
          FIN: begin
            dump_fin <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
